// File: rtl/dram_req_arbiter.sv
// Shares the single DDR command port between the capture write path and the readback read path.
// Commands are registered and appear one cycle after an accept; bounded write bursts, read starvation guard, read-in-flight cap.
module dram_req_arbiter #(
  parameter int WR_BURST_MAX       = 8,
  parameter int RD_BURST_MAX       = 4,
  parameter int MAX_RD_OUTSTANDING = 8,
  parameter int RD_STARVE_LIMIT    = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         capture_active,
  input  logic         wr_req,
  input  logic [26:0]  wr_adx,
  input  logic [127:0] wr_data,
  output logic         wr_allowed,
  input  logic         rd_req,
  input  logic [26:0]  rd_adx,
  output logic         rd_allowed,
  output logic         mem_write_req,
  output logic [26:0]  mem_wr_adx,
  output logic [127:0] mem_wr_data,
  input  logic         mem_write_allowed,
  output logic         mem_read_req,
  output logic [26:0]  mem_rd_adx,
  input  logic         mem_read_allowed,
  input  logic         rd_return_pop,
  output logic [3:0]   rd_outstanding,
  output logic [1:0]   arb_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam int BURST_TOP_I = (WR_BURST_MAX > RD_BURST_MAX) ? WR_BURST_MAX : RD_BURST_MAX;
  localparam int BW = $clog2(BURST_TOP_I + 1);
  localparam int SW = $clog2(RD_STARVE_LIMIT + 1);
  localparam logic [BW-1:0] WR_BURST_TOP = BW'(WR_BURST_MAX);
  localparam logic [BW-1:0] RD_BURST_TOP = BW'(RD_BURST_MAX);
  localparam logic [SW-1:0] STARVE_TOP   = SW'(RD_STARVE_LIMIT);
  localparam logic [3:0]    RD_OUT_TOP   = 4'(MAX_RD_OUTSTANDING);

  state_e         state_q, state_d;
  logic           last_grant_rd_q, last_grant_rd_d;
  logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
  logic [SW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [3:0]     rd_out_q, rd_out_d;
  logic           mem_write_req_q, mem_write_req_d;
  logic [26:0]    mem_wr_adx_q, mem_wr_adx_d;
  logic [127:0]   mem_wr_data_q, mem_wr_data_d;
  logic           mem_read_req_q, mem_read_req_d;
  logic [26:0]    mem_rd_adx_q, mem_rd_adx_d;
  logic           wr_acc, rd_acc;

  // A pending command blocks the next accept, capping each direction at one accept per two cycles.
  assign wr_allowed = (state_q == ST_WRITE) & mem_write_allowed & ~mem_write_req_q;
  assign rd_allowed = (state_q == ST_READ) & mem_read_allowed & ~mem_read_req_q &
                      (rd_out_q < RD_OUT_TOP);
  assign wr_acc = wr_req & wr_allowed;
  assign rd_acc = rd_req & rd_allowed;

  always_comb begin
    state_d         = state_q;
    last_grant_rd_d = last_grant_rd_q;
    burst_cnt_d     = burst_cnt_q;
    starve_cnt_d    = starve_cnt_q;
    rd_out_d        = rd_out_q;
    mem_write_req_d = wr_acc;
    mem_wr_adx_d    = wr_acc ? wr_adx : mem_wr_adx_q;
    mem_wr_data_d   = wr_acc ? wr_data : mem_wr_data_q;
    mem_read_req_d  = rd_acc;
    mem_rd_adx_d    = rd_acc ? rd_adx : mem_rd_adx_q;

    if (!rd_req || rd_acc) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STARVE_TOP) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    case ({rd_acc, rd_return_pop})
      2'b10:   rd_out_d = rd_out_q + 4'd1;
      2'b01:   rd_out_d = (rd_out_q != 4'd0) ? rd_out_q - 4'd1 : rd_out_q;
      default: rd_out_d = rd_out_q;
    endcase

    if ((state_q == ST_WRITE && wr_acc && burst_cnt_q != WR_BURST_TOP) ||
        (state_q == ST_READ && rd_acc && burst_cnt_q != RD_BURST_TOP)) begin
      burst_cnt_d = burst_cnt_q + BW'(1);
    end

    // Exits only on non-accept cycles, so they see counts that already include the last accept.
    case (state_q)
      ST_IDLE: begin
        if (wr_req && (starve_cnt_q < STARVE_TOP) &&
            (capture_active || !rd_req || last_grant_rd_q)) begin
          state_d         = ST_WRITE;
          burst_cnt_d     = '0;
          last_grant_rd_d = 1'b0;
        end else if (rd_req) begin
          state_d         = ST_READ;
          burst_cnt_d     = '0;
          last_grant_rd_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (!wr_acc && ((!wr_req && !mem_write_req_q) ||
                        (burst_cnt_q == WR_BURST_TOP && rd_req && !capture_active) ||
                        (starve_cnt_q >= STARVE_TOP))) begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (!rd_acc && (!rd_req || burst_cnt_q == RD_BURST_TOP || rd_out_q == RD_OUT_TOP)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      last_grant_rd_q <= 1'b1;
      burst_cnt_q     <= '0;
      starve_cnt_q    <= '0;
      rd_out_q        <= '0;
      mem_write_req_q <= 1'b0;
      mem_wr_adx_q    <= '0;
      mem_wr_data_q   <= '0;
      mem_read_req_q  <= 1'b0;
      mem_rd_adx_q    <= '0;
    end else begin
      state_q         <= state_d;
      last_grant_rd_q <= last_grant_rd_d;
      burst_cnt_q     <= burst_cnt_d;
      starve_cnt_q    <= starve_cnt_d;
      rd_out_q        <= rd_out_d;
      mem_write_req_q <= mem_write_req_d;
      mem_wr_adx_q    <= mem_wr_adx_d;
      mem_wr_data_q   <= mem_wr_data_d;
      mem_read_req_q  <= mem_read_req_d;
      mem_rd_adx_q    <= mem_rd_adx_d;
    end
  end

  assign mem_write_req  = mem_write_req_q;
  assign mem_wr_adx     = mem_wr_adx_q;
  assign mem_wr_data    = mem_wr_data_q;
  assign mem_read_req   = mem_read_req_q;
  assign mem_rd_adx     = mem_rd_adx_q;
  assign rd_outstanding = rd_out_q;
  assign arb_state      = state_q;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed bench for dram_req_arbiter: each task drives one scenario and checks hand-computed cycle results.
module tb_dram_req_arbiter;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         capture_active = 1'b0;
  logic         wr_req = 1'b0;
  logic [26:0]  wr_adx = '0;
  logic [127:0] wr_data = '0;
  logic         wr_allowed;
  logic         rd_req = 1'b0;
  logic [26:0]  rd_adx = '0;
  logic         rd_allowed;
  logic         mem_write_req;
  logic [26:0]  mem_wr_adx;
  logic [127:0] mem_wr_data;
  logic         mem_write_allowed = 1'b0;
  logic         mem_read_req;
  logic [26:0]  mem_rd_adx;
  logic         mem_read_allowed = 1'b0;
  logic         rd_return_pop = 1'b0;
  logic [3:0]   rd_outstanding;
  logic [1:0]   arb_state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] D10 = 128'hDEAD0010_BEEF0010_CAFE0010_12340010;
  localparam logic [127:0] D20 = 128'hDEAD0020_BEEF0020_CAFE0020_12340020;
  localparam logic [127:0] D30 = 128'hDEAD0030_BEEF0030_CAFE0030_12340030;

  dram_req_arbiter dut (
    .clk(clk), .reset(reset), .capture_active(capture_active),
    .wr_req(wr_req), .wr_adx(wr_adx), .wr_data(wr_data), .wr_allowed(wr_allowed),
    .rd_req(rd_req), .rd_adx(rd_adx), .rd_allowed(rd_allowed),
    .mem_write_req(mem_write_req), .mem_wr_adx(mem_wr_adx), .mem_wr_data(mem_wr_data),
    .mem_write_allowed(mem_write_allowed),
    .mem_read_req(mem_read_req), .mem_rd_adx(mem_rd_adx), .mem_read_allowed(mem_read_allowed),
    .rd_return_pop(rd_return_pop), .rd_outstanding(rd_outstanding), .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Leaves the bench in the input phase of cycle 0, the first cycle with reset low.
  task automatic do_reset;
    next_cycle();
    reset = 1'b1; capture_active = 1'b0; wr_req = 1'b0; wr_adx = '0; wr_data = '0;
    rd_req = 1'b0; rd_adx = '0; mem_write_allowed = 1'b0; mem_read_allowed = 1'b0; rd_return_pop = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    settle();
    n_cmp++; if (arb_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", arb_state); end
    n_cmp++; if (mem_write_req !== 1'b0 || mem_read_req !== 1'b0) begin n_err++; $display("FAIL rst_reqs: got wr=%0b rd=%0b want 0 0", mem_write_req, mem_read_req); end
    n_cmp++; if (mem_wr_adx !== 27'd0 || mem_rd_adx !== 27'd0 || mem_wr_data !== 128'd0) begin n_err++; $display("FAIL rst_adx: got wa=%0h ra=%0h wd=%0h want 0", mem_wr_adx, mem_rd_adx, mem_wr_data); end
    n_cmp++; if (rd_outstanding !== 4'd0) begin n_err++; $display("FAIL rst_outstanding: got %0d want 0", rd_outstanding); end
    n_cmp++; if (wr_allowed !== 1'b0 || rd_allowed !== 1'b0) begin n_err++; $display("FAIL rst_allowed: got %0b %0b want 0 0", wr_allowed, rd_allowed); end
    rd_return_pop = 1'b1;
    next_cycle();
    rd_return_pop = 1'b0;
    settle();
    n_cmp++; if (rd_outstanding !== 4'd0) begin n_err++; $display("FAIL pop_at_zero: got %0d want 0", rd_outstanding); end
    n_cmp++; if (arb_state !== 2'd0) begin n_err++; $display("FAIL idle_no_req: got %0d want 0", arb_state); end
  endtask

  task automatic test_write_basic;
    do_reset();
    wr_req = 1'b1; wr_adx = 27'h10; wr_data = D10; mem_write_allowed = 1'b1; mem_read_allowed = 1'b1;
    settle();
    n_cmp++; if (arb_state !== 2'd0) begin n_err++; $display("FAIL wb_c0_state: got %0d want 0", arb_state); end
    next_cycle(); settle();
    n_cmp++; if (arb_state !== 2'd1 || wr_allowed !== 1'b1 || mem_write_req !== 1'b0) begin n_err++; $display("FAIL wb_c1: got st=%0d alw=%0b req=%0b want 1 1 0", arb_state, wr_allowed, mem_write_req); end
    next_cycle(); wr_adx = 27'h20; wr_data = D20; settle();
    n_cmp++; if (mem_write_req !== 1'b1 || mem_wr_adx !== 27'h10 || mem_wr_data !== D10) begin n_err++; $display("FAIL wb_cmd1: got req=%0b adx=%0h data=%0h want 1 10", mem_write_req, mem_wr_adx, mem_wr_data); end
    n_cmp++; if (wr_allowed !== 1'b0) begin n_err++; $display("FAIL wb_gap: got wr_allowed=%0b want 0", wr_allowed); end
    next_cycle(); settle();
    n_cmp++; if (mem_write_req !== 1'b0 || mem_wr_adx !== 27'h10 || wr_allowed !== 1'b1) begin n_err++; $display("FAIL wb_c3: got req=%0b adx=%0h alw=%0b want 0 10 1", mem_write_req, mem_wr_adx, wr_allowed); end
    next_cycle(); wr_adx = 27'h30; wr_data = D30; settle();
    n_cmp++; if (mem_write_req !== 1'b1 || mem_wr_adx !== 27'h20 || mem_wr_data !== D20) begin n_err++; $display("FAIL wb_cmd2: got req=%0b adx=%0h want 1 20", mem_write_req, mem_wr_adx); end
    next_cycle(); settle();
    n_cmp++; if (wr_allowed !== 1'b1) begin n_err++; $display("FAIL wb_c5: got wr_allowed=%0b want 1", wr_allowed); end
    next_cycle(); wr_req = 1'b0; settle();
    n_cmp++; if (mem_write_req !== 1'b1 || mem_wr_adx !== 27'h30 || mem_wr_data !== D30 || arb_state !== 2'd1) begin n_err++; $display("FAIL wb_cmd3: got req=%0b adx=%0h st=%0d want 1 30 1", mem_write_req, mem_wr_adx, arb_state); end
    next_cycle(); settle();
    n_cmp++; if (arb_state !== 2'd1 || mem_write_req !== 1'b0) begin n_err++; $display("FAIL wb_c7: got st=%0d req=%0b want 1 0", arb_state, mem_write_req); end
    next_cycle(); settle();
    n_cmp++; if (arb_state !== 2'd0) begin n_err++; $display("FAIL wb_exit: got st=%0d want 0", arb_state); end
  endtask

  task automatic test_starve;
    int wr_cnt = 0;
    int rd_first = -1;
    int req_first = -1;
    do_reset();
    capture_active = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_adx = 27'h40; wr_data = 128'h1; rd_adx = 27'h5A;
    mem_write_allowed = 1'b1; mem_read_allowed = 1'b1;
    for (int c = 0; c <= 70; c++) begin
      if (c > 0) next_cycle();
      settle();
      if (c <= 64 && wr_req && wr_allowed) wr_cnt++;
      if (rd_allowed && rd_first < 0) rd_first = c;
      if (mem_read_req && req_first < 0) req_first = c;
      if (c == 65) begin
        n_cmp++; if (arb_state !== 2'd0) begin n_err++; $display("FAIL starve_bubble: got st=%0d want 0", arb_state); end
      end
      if (c == 67) begin
        n_cmp++; if (dut.starve_cnt_q !== 7'd0) begin n_err++; $display("FAIL starve_clear: got %0d want 0", dut.starve_cnt_q); end
        n_cmp++; if (mem_rd_adx !== 27'h5A) begin n_err++; $display("FAIL starve_rd_adx: got %0h want 5a", mem_rd_adx); end
      end
    end
    n_cmp++; if (wr_cnt != 32) begin n_err++; $display("FAIL starve_wr_cnt: got %0d want 32", wr_cnt); end
    n_cmp++; if (rd_first != 66) begin n_err++; $display("FAIL starve_first_accept: got cycle %0d want 66", rd_first); end
    n_cmp++; if (req_first != 67) begin n_err++; $display("FAIL starve_first_cmd: got cycle %0d want 67", req_first); end
  endtask

  task automatic test_alternate;
    int exp_st [52];
    int wr_cnt = 0;
    int rd_cnt = 0;
    for (int i = 0; i < 52; i++) exp_st[i] = 0;
    for (int i = 1; i <= 16; i++) exp_st[i] = 1;
    for (int i = 18; i <= 25; i++) exp_st[i] = 2;
    for (int i = 27; i <= 42; i++) exp_st[i] = 1;
    for (int i = 44; i <= 51; i++) exp_st[i] = 2;
    do_reset();
    capture_active = 1'b0; wr_req = 1'b1; rd_req = 1'b1; wr_adx = 27'h77; rd_adx = 27'h66;
    mem_write_allowed = 1'b1; mem_read_allowed = 1'b1;
    for (int c = 0; c < 52; c++) begin
      if (c > 0) next_cycle();
      settle();
      if (wr_req && wr_allowed) wr_cnt++;
      if (rd_req && rd_allowed) rd_cnt++;
      n_cmp++; if (int'(arb_state) != exp_st[c]) begin n_err++; $display("FAIL alt_state c%0d: got %0d want %0d", c, arb_state, exp_st[c]); end
    end
    n_cmp++; if (wr_cnt != 16 || rd_cnt != 8) begin n_err++; $display("FAIL alt_counts: got wr=%0d rd=%0d want 16 8", wr_cnt, rd_cnt); end
  endtask

  task automatic test_outstanding;
    int acc = 0;
    int got = 0;
    do_reset();
    rd_req = 1'b1; rd_adx = 27'h333; mem_read_allowed = 1'b1; mem_write_allowed = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c > 0) next_cycle();
      settle();
      if (rd_req && rd_allowed) acc++;
    end
    n_cmp++; if (acc != 8) begin n_err++; $display("FAIL out_accepts: got %0d want 8", acc); end
    n_cmp++; if (rd_outstanding !== 4'd8 || rd_allowed !== 1'b0) begin n_err++; $display("FAIL out_full: got cnt=%0d alw=%0b want 8 0", rd_outstanding, rd_allowed); end
    rd_return_pop = 1'b1;
    next_cycle(); rd_return_pop = 1'b0; settle();
    n_cmp++; if (rd_outstanding !== 4'd7) begin n_err++; $display("FAIL out_pop: got %0d want 7", rd_outstanding); end
    for (int c = 0; c < 10 && got == 0; c++) begin
      if (rd_allowed) got = 1;
      else begin next_cycle(); settle(); end
    end
    n_cmp++; if (got != 1) begin n_err++; $display("FAIL out_ninth_timeout: got %0d want 1", got); end
    next_cycle(); settle();
    n_cmp++; if (rd_outstanding !== 4'd8 || mem_read_req !== 1'b1) begin n_err++; $display("FAIL out_ninth: got cnt=%0d req=%0b want 8 1", rd_outstanding, mem_read_req); end
    rd_return_pop = 1'b1;
    next_cycle(); rd_return_pop = 1'b0; settle();
    n_cmp++; if (rd_outstanding !== 4'd7) begin n_err++; $display("FAIL out_pop2: got %0d want 7", rd_outstanding); end
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      if (rd_allowed) got = 1;
      else begin next_cycle(); settle(); end
    end
    n_cmp++; if (got != 1) begin n_err++; $display("FAIL out_simul_timeout: got %0d want 1", got); end
    rd_return_pop = 1'b1;
    settle();
    next_cycle(); rd_return_pop = 1'b0; settle();
    n_cmp++; if (rd_outstanding !== 4'd7 || mem_read_req !== 1'b1) begin n_err++; $display("FAIL out_simul: got cnt=%0d req=%0b want 7 1", rd_outstanding, mem_read_req); end
  endtask

  task automatic test_backpressure;
    do_reset();
    wr_req = 1'b1; wr_adx = 27'h100; wr_data = 128'h5555; mem_write_allowed = 1'b1;
    settle();
    for (int c = 1; c <= 10; c++) begin
      next_cycle();
      if (c == 1) mem_write_allowed = 1'b0;
      settle();
      n_cmp++; if (wr_allowed !== 1'b0 || arb_state !== 2'd1 || mem_write_req !== 1'b0) begin n_err++; $display("FAIL bp_hold c%0d: got alw=%0b st=%0d req=%0b want 0 1 0", c, wr_allowed, arb_state, mem_write_req); end
    end
    next_cycle(); mem_write_allowed = 1'b1; settle();
    n_cmp++; if (wr_allowed !== 1'b1 || arb_state !== 2'd1) begin n_err++; $display("FAIL bp_release: got alw=%0b st=%0d want 1 1", wr_allowed, arb_state); end
    next_cycle(); settle();
    n_cmp++; if (mem_write_req !== 1'b1 || mem_wr_adx !== 27'h100 || mem_wr_data !== 128'h5555) begin n_err++; $display("FAIL bp_cmd: got req=%0b adx=%0h want 1 100", mem_write_req, mem_wr_adx); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    rd_req = 1'b1; rd_adx = 27'h7ABCDEF; mem_read_allowed = 1'b1; mem_write_allowed = 1'b1;
    settle();
    for (int c = 1; c <= 6; c++) begin next_cycle(); settle(); end
    n_cmp++; if (mem_read_req !== 1'b1 || rd_outstanding !== 4'd3 || arb_state !== 2'd2 || mem_rd_adx !== 27'h7ABCDEF) begin n_err++; $display("FAIL rm_pre: got req=%0b cnt=%0d st=%0d adx=%0h want 1 3 2 7abcdef", mem_read_req, rd_outstanding, arb_state, mem_rd_adx); end
    reset = 1'b1;
    next_cycle(); reset = 1'b0; settle();
    n_cmp++; if (arb_state !== 2'd0 || mem_read_req !== 1'b0 || rd_outstanding !== 4'd0) begin n_err++; $display("FAIL rm_post: got st=%0d req=%0b cnt=%0d want 0 0 0", arb_state, mem_read_req, rd_outstanding); end
    n_cmp++; if (mem_rd_adx !== 27'd0 || mem_wr_adx !== 27'd0 || mem_wr_data !== 128'd0) begin n_err++; $display("FAIL rm_adx: got ra=%0h wa=%0h wd=%0h want 0", mem_rd_adx, mem_wr_adx, mem_wr_data); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_starve();
    test_alternate();
    test_outstanding();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dram_req_arbiter.md
Name: dram_req_arbiter

Overview:
- Shares the single command port of ddr_memory_interface between two requesters: the capture write path (dram_packer) and the readback read path (LogicCaptureTop).
- Writes have priority while a capture is active. A starvation counter forces readback service after a bounded wait.
- Limits reads in flight, so the return-data buffer in ddr_memory_interface cannot overflow.
- Sits between dram_packer/LogicCaptureTop and ddr_memory_interface, in the soc_clk domain.

Parameters:
- WR_BURST_MAX, 8: max write accepts per WRITE grant when reads are waiting.
- RD_BURST_MAX, 4: max read accepts per READ grant.
- MAX_RD_OUTSTANDING, 8: max reads accepted but not yet popped from return data.
- RD_STARVE_LIMIT, 64: cycles a waiting read may be denied before it is forced in.

Ports:
- clk  in  1  soc_clk, 100 MHz; the only clock.
- reset  in  1  synchronous, active-high.
- capture_active  in  1  high while sampling is running; gives writes priority.
- wr_req  in  1  write requester holds a valid write.
- wr_adx  in  27  write address.
- wr_data  in  128  write data.
- wr_allowed  out  1  write accepted this cycle if wr_req is high.
- rd_req  in  1  read requester holds a valid read.
- rd_adx  in  27  read address.
- rd_allowed  out  1  read accepted this cycle if rd_req is high.
- mem_write_req  out  1  one-cycle write command to ddr_memory_interface.
- mem_wr_adx  out  27  registered write address.
- mem_wr_data  out  128  registered write data.
- mem_write_allowed  in  1  ddr_memory_interface can take a write.
- mem_read_req  out  1  one-cycle read command.
- mem_rd_adx  out  27  registered read address.
- mem_read_allowed  in  1  ddr_memory_interface can take a read.
- rd_return_pop  in  1  has_return_data AND get_return_data; one return consumed.
- rd_outstanding  out  4  reads in flight, range 0..MAX_RD_OUTSTANDING.
- arb_state  out  2  0 = IDLE, 1 = WRITE, 2 = READ.

Behaviour:
- Reset (synchronous, highest priority): applies mid-operation and drops any registered command.
  - state IDLE.
  - All counters 0.
  - mem_write_req and mem_read_req 0.
  - mem_wr_adx, mem_wr_data and mem_rd_adx 0.
  - last_grant = READ, so the first contested grant goes to WRITE.
- Accept rules:
  - wr_allowed = (state==WRITE) & mem_write_allowed & ~mem_write_req.
  - rd_allowed = (state==READ) & mem_read_allowed & ~mem_read_req & (rd_outstanding < MAX_RD_OUTSTANDING).
  - A write is accepted on a cycle with wr_req & wr_allowed; a read on rd_req & rd_allowed.
  - Maximum rate is one accept per 2 cycles per direction.
- Latency: on the cycle after an accept, the matching mem_*_req is 1 for exactly one cycle, with the address/data captured at accept. Registered outputs hold their value otherwise.
- State machine. Each transition costs one cycle; a change of grant always passes through IDLE, giving a one-cycle bubble.
  - IDLE → WRITE if wr_req & (starve_cnt < RD_STARVE_LIMIT) & (capture_active | ~rd_req | last_grant==READ).
  - IDLE → READ otherwise, if rd_req.
  - IDLE stays IDLE if there are no requests.
  - Entering WRITE or READ clears burst_cnt and sets last_grant.
  - WRITE → IDLE when any of these holds:
    - ~wr_req and no write command pending;
    - burst_cnt==WR_BURST_MAX & rd_req & ~capture_active;
    - starve_cnt ≥ RD_STARVE_LIMIT.
  - READ → IDLE when ~rd_req, or burst_cnt==RD_BURST_MAX, or rd_outstanding==MAX_RD_OUTSTANDING.
  - Exit is evaluated using post-accept counts. A state is never left in the same cycle as its own accept; the exit is taken the following cycle.
- burst_cnt: increments on each accept in the current state and saturates at its MAX.
- starve_cnt:
  - increments each cycle with rd_req & ~(rd_req & rd_allowed); saturates at RD_STARVE_LIMIT.
  - clears on any read accept, or when rd_req is 0.
  - when saturated in IDLE, READ is forced even if wr_req & capture_active.
- rd_outstanding:
  - +1 on read accept, −1 on rd_return_pop; a simultaneous accept and pop leaves it unchanged.
  - A pop at 0 is ignored: the counter stays 0.
  - Never exceeds MAX_RD_OUTSTANDING, because rd_allowed is gated.
- Backpressure: mem_*_allowed falling while a state is held only stalls accepts. It does not change state.
- Address/data are never modified; the block performs no width arithmetic other than the counters.

Test Plan:
- Reset, then wr_req=1 alone with mem_write_allowed=1, addresses 0x10, 0x20, 0x30 → mem_write_req pulses 1 cycle after each accept, every 2 cycles, with matching adx/data; arb_state=1.
- capture_active=1, wr_req and rd_req both held, RD_STARVE_LIMIT=64 → no read accepted for 64 cycles. WRITE then exits to IDLE and READ is granted; first mem_read_req at cycle ≤ 67; starve_cnt returns to 0.
- capture_active=0, both requests held → alternating grants of 8 writes then 4 reads, with one IDLE bubble between each.
- Reads only, rd_return_pop=0 → exactly 8 reads accepted, rd_outstanding=8, rd_allowed=0. One pop → rd_outstanding=7 and a ninth read is accepted. Pop in the same cycle as an accept → count unchanged.
- mem_write_allowed=0 for 10 cycles while in WRITE → no accepts, state stays WRITE, mem_write_req=0. On release, the next write is accepted in the same cycle.
- Assert reset for 1 cycle while in READ with mem_read_req pending and rd_outstanding=3 → next cycle: state IDLE, mem_read_req=0, rd_outstanding=0, all address outputs 0.
